// File: rtl/opb_bank_pkg.sv
// Shared constants and helpers for the OPB register bank.
// Byte lanes and control-register bits are in user-bit order (bit 0 = LSB).
package opb_bank_pkg;

  localparam int COMMIT_BIT = 0;
  localparam int DIRTY_BIT  = 0;
  localparam int SHADOW_BIT = 1;

  // Replace the byte lanes whose enable is set; the other lanes keep the old value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] w_res;
    w_res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w_res[8*b +: 8] = new_val[8*b +: 8];
    end
    return w_res;
  endfunction

  // Enough index bits to address every user register plus the control word.
  function automatic int idx_width(input int num_regs);
    return (num_regs < 1) ? 1 : $clog2(num_regs + 1);
  endfunction

endpackage

// File: rtl/opb_bank_reg.sv
// One bank register: an optional shadow copy, the active value seen by the fabric,
// a one-cycle update strobe, and an optional self-clear of the active value.
module opb_bank_reg
  import opb_bank_pkg::*;
#(
  parameter bit P_PULSE  = 1'b0,
  parameter bit P_SHADOW = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  input  logic        i_commit,
  output logic [31:0] o_active,
  output logic [31:0] o_shadow,
  output logic        o_update
);

  logic [31:0] r_active;
  logic [31:0] r_shadow;
  logic        r_update;
  logic        w_load_direct;
  logic        w_load_commit;

  assign w_load_direct = !P_SHADOW && i_wr;
  assign w_load_commit = P_SHADOW && i_commit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active <= '0;
      r_shadow <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_load_direct || w_load_commit;
      if (P_SHADOW && i_wr) r_shadow <= be_merge(r_shadow, i_wdata, i_be);
      // A load takes priority over the pulse clear, so a write in the clearing cycle sticks.
      if (w_load_direct)      r_active <= be_merge(r_active, i_wdata, i_be);
      else if (w_load_commit) r_active <= r_shadow;
      else if (P_PULSE)       r_active <= '0;
    end
  end

  assign o_active = r_active;
  assign o_shadow = r_shadow;
  assign o_update = r_update;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software-writable 32-bit control registers to fabric,
// with byte-enable writes, readback, update strobes, pulse registers and shadow/commit.
module opb_register_bank_ppc2simulink
  import opb_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01000F00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01000FFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter int          C_SHADOW_EN  = 0,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_update
);

  localparam int IDX_W    = idx_width(C_NUM_REGS);
  localparam bit L_SHADOW = (C_SHADOW_EN != 0);

  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic [31:0]      w_offset;
  logic [31:0]      w_word;
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic             w_wr;
  logic             w_is_reg;
  logic             w_is_ctrl;
  logic             w_commit;
  logic [31:0]      w_rdata;
  logic [31:0]      w_active [C_NUM_REGS];
  logic [31:0]      w_shadow [C_NUM_REGS];
  logic             r_ack;
  logic             r_dirty;
  logic [31:0]      r_dbus;
  logic             w_unused;
  logic [$bits(C_FAMILY)-1:0] w_family_unused;

  // Ascending OPB vectors land MSB-first, so OPB bit 0 becomes user bit 31 with no swizzle.
  assign w_addr  = OPB_ABus;
  assign w_wdata = OPB_DBus;
  assign w_be    = OPB_BE;

  assign w_offset  = w_addr - C_BASEADDR;
  assign w_word    = {2'b00, w_offset[31:2]};
  assign w_idx     = w_word[IDX_W-1:0];
  assign w_is_reg  = w_word < 32'(C_NUM_REGS);
  assign w_is_ctrl = w_word == 32'(C_NUM_REGS);

  assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR) && !r_ack;
  assign w_wr     = w_hit && !OPB_RNW;
  assign w_commit = w_wr && w_is_ctrl && w_wdata[COMMIT_BIT] && w_be[COMMIT_BIT/8];

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
    opb_bank_reg #(
      .P_PULSE  (C_PULSE_MASK[g]),
      .P_SHADOW (L_SHADOW)
    ) u_reg (
      .i_clk    (OPB_Clk),
      .i_rst_n  (OPB_Rst_n),
      .i_wr     (w_wr && w_is_reg && (w_idx == IDX_W'(g))),
      .i_be     (w_be),
      .i_wdata  (w_wdata),
      .i_commit (w_commit),
      .o_active (w_active[g]),
      .o_shadow (w_shadow[g]),
      .o_update (user_update[g])
    );
    assign user_data_out[32*g +: 32] = w_active[g];
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      w_rdata[DIRTY_BIT]  = r_dirty;
      w_rdata[SHADOW_BIT] = L_SHADOW;
    end
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (w_is_reg && (w_idx == IDX_W'(i)))
        w_rdata = L_SHADOW ? w_shadow[i] : w_active[i];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_ack   <= 1'b0;
      r_dirty <= 1'b0;
      r_dbus  <= '0;
    end else begin
      r_ack  <= w_hit;
      // Drive zero outside the ack cycle so the slave can sit on a wired-OR bus.
      r_dbus <= (w_hit && OPB_RNW) ? w_rdata : '0;
      if (w_commit)
        r_dirty <= 1'b0;
      else if (L_SHADOW && w_wr && w_is_reg)
        r_dirty <= 1'b1;
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_family_unused = C_FAMILY;
  assign w_unused        = ^{OPB_seqAddr, w_offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: three configurations share one bus and are checked
// every cycle against an array-based model of the register bank.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01000F00;
  localparam logic [31:0] HIGH = 32'h01000FFF;
  localparam int          ND   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq_addr;

  logic [0:31]  sl_dbus [ND];
  logic         ack     [ND];
  logic         err_ack [ND];
  logic         retry   [ND];
  logic         tout    [ND];
  logic [255:0] udo     [ND];
  logic [7:0]   upd     [ND];

  logic [31:0] m_act  [ND][8];
  logic [31:0] m_shd  [ND][8];
  logic        m_dirty[ND];
  logic        m_ack  [ND];
  logic [31:0] m_dbus [ND];
  logic [7:0]  m_upd  [ND];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_SHADOW_EN(0), .C_PULSE_MASK(64'h0)) u_dut0 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr), .Sl_DBus(sl_dbus[0]),
    .Sl_xferAck(ack[0]), .Sl_errAck(err_ack[0]), .Sl_retry(retry[0]), .Sl_toutSup(tout[0]),
    .user_data_out(udo[0]), .user_update(upd[0]));

  opb_register_bank_ppc2simulink #(.C_SHADOW_EN(1), .C_PULSE_MASK(64'h0)) u_dut1 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr), .Sl_DBus(sl_dbus[1]),
    .Sl_xferAck(ack[1]), .Sl_errAck(err_ack[1]), .Sl_retry(retry[1]), .Sl_toutSup(tout[1]),
    .user_data_out(udo[1]), .user_update(upd[1]));

  opb_register_bank_ppc2simulink #(.C_SHADOW_EN(0), .C_PULSE_MASK(64'h4)) u_dut2 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr), .Sl_DBus(sl_dbus[2]),
    .Sl_xferAck(ack[2]), .Sl_errAck(err_ack[2]), .Sl_retry(retry[2]), .Sl_toutSup(tout[2]),
    .user_data_out(udo[2]), .user_update(upd[2]));

  function automatic bit shadow_of(input int d);
    return d == 1;
  endfunction

  function automatic bit pulse_of(input int d, input int i);
    return (d == 2) && (i == 2);
  endfunction

  task automatic chk_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of bank behaviour to the model, using the inputs now on the bus.
  task automatic model_edge();
    logic [31:0] a, wd, mask, rd, word;
    logic [7:0]  nu;
    logic        hit;
    a  = abus;
    wd = dbus;
    mask = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) mask[31-8*b -: 8] = 8'hFF;
    word = (a - BASE) / 4;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin m_act[d][i] = '0; m_shd[d][i] = '0; end
        m_dirty[d] = 1'b0; m_ack[d] = 1'b0; m_dbus[d] = '0; m_upd[d] = '0;
      end else begin
        hit = sel && (a >= BASE) && (a <= HIGH) && !m_ack[d];
        rd  = '0;
        if (word < 8)       rd = shadow_of(d) ? m_shd[d][word] : m_act[d][word];
        else if (word == 8) rd = {30'd0, shadow_of(d), m_dirty[d]};
        nu = '0;
        for (int i = 0; i < 8; i++)
          if (pulse_of(d, i)) m_act[d][i] = '0;
        if (hit && !rnw) begin
          if (word < 8) begin
            if (shadow_of(d)) begin
              m_shd[d][word] = (m_shd[d][word] & ~mask) | (wd & mask);
              m_dirty[d] = 1'b1;
            end else begin
              m_act[d][word] = (m_act[d][word] & ~mask) | (wd & mask);
              nu[word] = 1'b1;
            end
          end else if (word == 8 && dbus[31] && be[3] && shadow_of(d)) begin
            for (int i = 0; i < 8; i++) m_act[d][i] = m_shd[d][i];
            nu = 8'hFF;
            m_dirty[d] = 1'b0;
          end
        end
        m_ack[d]  = hit;
        m_dbus[d] = (hit && rnw) ? rd : '0;
        m_upd[d]  = nu;
      end
    end
  endtask

  task automatic check_all();
    logic [255:0] eu;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 8; i++) eu[32*i +: 32] = m_act[d][i];
      chk_val($sformatf("d%0d ack", d), ack[d], m_ack[d]);
      chk_val($sformatf("d%0d dbus", d), sl_dbus[d], m_dbus[d]);
      chk_val($sformatf("d%0d data_out", d), udo[d], eu);
      chk_val($sformatf("d%0d update", d), upd[d], m_upd[d]);
      chk_val($sformatf("d%0d tied", d), {err_ack[d], retry[d], tout[d]}, 3'b000);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic start(input logic [31:0] a, input logic r, input logic [3:0] b, input logic [31:0] dat);
    abus = a; rnw = r; be = b; dbus = dat; sel = 1'b1;
  endtask

  task automatic stop();
    sel = 1'b0; dbus = $urandom; be = 4'($urandom); abus = $urandom;
  endtask

  task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                      input logic [31:0] dat, input bit hold);
    start(a, r, b, dat);
    tick();
    if (hold) tick();
    stop();
    tick();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 8; i++) begin m_act[d][i] = '0; m_shd[d][i] = '0; end
      m_dirty[d] = 1'b0; m_ack[d] = 1'b0; m_dbus[d] = '0; m_upd[d] = '0;
    end
    rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus = '0; seq_addr = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_val("reset data_out", udo[0], 256'd0);

    for (int i = 0; i < 8; i++) xfer(BASE + 32'(4*i), 1'b1, 4'hF, 32'h0, i == 0);
    xfer(BASE + 32'h20, 1'b1, 4'hF, 32'h0, 1'b1);

    // Byte-enabled writes on the direct-write banks.
    xfer(BASE + 32'hC, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0);
    xfer(BASE + 32'hC, 1'b0, 4'b0100, 32'h00AA0000, 1'b1);
    chk_val("be merge d0", udo[0][127:96], 32'hDEAABEEF);
    xfer(BASE + 32'hC, 1'b1, 4'hF, 32'h0, 1'b0);

    // Shadow writes, dirty readback, then commit.
    xfer(BASE + 32'h0, 1'b0, 4'hF, 32'h11111111, 1'b0);
    xfer(BASE + 32'h4, 1'b0, 4'hF, 32'h22222222, 1'b0);
    chk_val("shadow hold d1", udo[1][63:0], 64'd0);
    start(BASE + 32'h20, 1'b1, 4'hF, 32'h0);
    tick();
    chk_val("ctrl dirty d1", sl_dbus[1], 32'h3);
    stop(); tick();
    start(BASE + 32'h20, 1'b0, 4'hF, 32'h1);
    tick();
    chk_val("commit data d1", udo[1][63:0], 64'h22222222_11111111);
    chk_val("commit update d1", upd[1], 8'hFF);
    stop(); tick();
    chk_val("commit strobe end d1", upd[1], 8'h00);
    xfer(BASE + 32'h20, 1'b1, 4'hF, 32'h0, 1'b0);

    // Pulse register 2 on d2.
    start(BASE + 32'h8, 1'b0, 4'hF, 32'h5);
    tick();
    chk_val("pulse high d2", udo[2][95:64], 32'h5);
    stop(); tick();
    chk_val("pulse clear d2", udo[2][95:64], 32'h0);
    xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0, 1'b0);

    // Unmapped word in the window and addresses outside it.
    xfer(BASE + 32'h80, 1'b0, 4'hF, 32'hFFFFFFFF, 1'b0);
    xfer(BASE + 32'h80, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(BASE - 32'h4, 1'b1, 4'hF, 32'h0, 1'b1);
    xfer(HIGH + 32'h1, 1'b0, 4'hF, 32'h12345678, 1'b1);

    // Reset arriving with a write hit drops the ack and clears everything.
    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0);
    start(BASE + 32'h14, 1'b0, 4'hF, 32'h0BADBEEF);
    rst_n = 1'b0;
    tick();
    chk_val("reset ack d0", ack[0], 1'b0);
    chk_val("reset data_out d0", udo[0], 256'd0);
    rst_n = 1'b1;
    stop(); tick();

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a, dat;
      int sel_kind;
      sel_kind = $urandom_range(0, 99);
      if (sel_kind < 75)      a = BASE + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3));
      else if (sel_kind < 88) a = BASE + 32'($urandom_range(0, 255));
      else if (sel_kind < 94) a = BASE - 32'($urandom_range(1, 64));
      else                    a = HIGH + 32'($urandom_range(1, 64));
      dat = $urandom;
      if ($urandom_range(0, 3) == 0) dat[0] = 1'b1;
      start(a, 1'($urandom), 4'($urandom), dat);
      if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      if ($urandom_range(0, 3) == 0) tick();
      stop();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- OPB slave holding C_NUM_REGS software-writable 32-bit control registers that drive fabric logic. Parametrised successor to the single-register PPC-to-fabric block.
- Adds per-register byte-enable writes, full readback, per-register update strobes, optional self-clearing (pulse) registers and an optional shadow/commit mode for atomic multi-register updates.
- Single clock domain: the fabric consumer runs on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01000F00, first byte address of the bank.
- C_HIGHADDR, 32'h01000FFF, last byte address decoded, acked when selected.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported).
- C_NUM_REGS, 8, number of user registers (1..64).
- C_PULSE_MASK, 0, bit i=1: register i self-clears one cycle after it takes a value.
- C_SHADOW_EN, 0, 1: writes land in shadow registers and are applied only on commit.
- C_FAMILY, "virtex5", target family string (informational).

Ports:
- OPB_Clk  in  1  bus and user clock
- OPB_Rst_n  in  1  synchronous active-low reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] maps to DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- user_data_out  out  [C_NUM_REGS*32-1:0]  active values; register i occupies bits [32i+31:32i]
- user_update  out  [C_NUM_REGS-1:0]  one-cycle strobe when register i's active value is loaded

Behaviour:
- Reset is synchronous and active-low on OPB_Rst_n. It clears all active and shadow registers, user_update, Sl_xferAck, the dirty flag, and Sl_DBus to 0.
- Hit condition: OPB_select=1, OPB_ABus within [C_BASEADDR, C_HIGHADDR], ack_q=0.
- Word index = (OPB_ABus - C_BASEADDR) >> 2.
- Ack timing: Sl_xferAck is registered, asserts exactly one cycle after the hit, and is held for one cycle only. ack_q blocks a second ack while OPB_select stays high in the ack cycle.
- Sl_DBus is 0 in every cycle where Sl_xferAck=0, as required for the OR-ed bus.
- Bit order: OPB bit 0 = user bit 31.
- Write to index i < C_NUM_REGS, in the hit cycle:
  - Only byte lanes with BE=1 are updated. With C_SHADOW_EN=0 the target is the active register; with C_SHADOW_EN=1 it is the shadow register.
  - C_SHADOW_EN=0: the new value appears on user_data_out on the ack cycle, with user_update[i]=1 for that cycle.
  - C_SHADOW_EN=1: the dirty flag is set; outputs are unchanged.
- Index C_NUM_REGS is the control register.
  - Write with DBus[31]=1 (user bit 0) and BE[3]=1 commits: all shadows are copied to the active registers in one cycle, user_update gets all ones for that cycle, and dirty clears.
  - Commit with C_SHADOW_EN=0 is a no-op but is still acked.
  - Read returns {30'b0, C_SHADOW_EN, dirty} in user-bit order.
- Read of index i < C_NUM_REGS returns the shadow value when C_SHADOW_EN=1, otherwise the active value. Readback is valid in the ack cycle.
- Indices > C_NUM_REGS inside the window are acked; they read 0 and writes are ignored.
- Pulse registers (C_PULSE_MASK[i]=1): the active value is held exactly one cycle, then cleared to 0. The clear does not raise user_update. The shadow is not cleared. A new write in the clearing cycle wins over the clear.
- The bus permits one access at a time, so a simultaneous write and commit cannot occur.
- Reset asserted mid-transfer: the pending ack is dropped, and the master times out or retries.

Decomposition:
- Shared package opb_bank_pkg holds:
  - control-register bit positions (COMMIT_BIT, DIRTY_BIT, SHADOW_BIT);
  - a byte-lane merge function;
  - an index-width function, clog2(C_NUM_REGS+1).
- Sub-module opb_bank_reg: one register with shadow, active, byte-enable merge and pulse-clear logic, instantiated C_NUM_REGS times by generate.

Test Plan:
- Reset, then read index 0..7 -> Sl_DBus=0, one ack per access, ack exactly one cycle after select, Sl_DBus=0 outside ack.
- C_SHADOW_EN=0: write 0xDEADBEEF to index 3 with BE=1111, then BE=0100 with 0x00AA0000 -> user_data_out[127:96]=0xDEAABEEF; user_update[3] pulses once per write.
- C_SHADOW_EN=1: write 0x11111111 to index 0 and 0x22222222 to index 1 -> outputs stay 0 and control reads dirty=1. Commit -> both outputs update in the same cycle, user_update=0xFF for one cycle, dirty=0.
- C_PULSE_MASK=8'h04: write 0x5 to index 2 -> user_data_out[95:64]=0x5 for one cycle then 0; readback of index 2 returns 0 (no shadow).
- Access at C_BASEADDR+0x80 (unmapped): write ignored, read returns 0, ack returned; addresses outside the window are never acked.
- Assert OPB_Rst_n=0 in the cycle after a write hit -> no ack, all outputs 0 the following cycle.
